// File: rtl/rv32i_memport_arbiter.sv
// Two-master (fetch / data) arbiter onto a single strobe/ack memory bus.
// Data has priority under contention, capped by a streak limit so fetch cannot starve.
//   state | meaning
//   IDLE  | sample requests, grant winner
//   XFER  | m_stb held, waiting for m_ack/m_err or timeout
//   RESP  | one-cycle ack/err pulse to the owner
module rv32i_memport_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_stb,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_sel,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic [SW-1:0]   streak_q;
  logic [TW-1:0]   tcnt_q;
  logic            grant_i, grant_d, done_ok, done_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || streak_q < SW'(MAX_D_STREAK))) grant_d = 1'b1;
        else if (i_req)                                         grant_i = 1'b1;
        if (grant_i || grant_d) state_d = XFER;
      end
      XFER: begin
        // error beats ack when both arrive together; timeout reports as error
        if (m_err)                            done_err = 1'b1;
        else if (m_ack)                       done_ok  = 1'b1;
        else if (tcnt_q == TW'(TIMEOUT - 1))  done_err = 1'b1;
        if (done_ok || done_err) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      streak_q <= '0;
      tcnt_q   <= '0;
      m_stb    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_sel    <= '0;
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= done_ok  & ~owner_q;
      i_err <= done_err & ~owner_q;
      d_ack <= done_ok  &  owner_q;
      d_err <= done_err &  owner_q;
      if (grant_i || grant_d) begin
        owner_q <= grant_d;
        m_stb   <= 1'b1;
        m_we    <= grant_d & d_we;
        m_addr  <= grant_d ? d_addr  : i_addr;
        m_wdata <= grant_d ? d_wdata : 32'h0;
        m_sel   <= grant_d ? d_sel   : 4'hF;
        tcnt_q  <= '0;
        if (grant_i)
          streak_q <= '0;
        else if (i_req && streak_q < SW'(MAX_D_STREAK))
          streak_q <= streak_q + 1'b1;
      end
      if (state_q == XFER) begin
        if (done_ok || done_err) m_stb <= 1'b0;
        if (!m_ack && !m_err)    tcnt_q <= tcnt_q + 1'b1;
        if (done_ok) begin
          if (owner_q) d_rdata <= m_rdata;
          else         i_rdata <= m_rdata;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rv32i_memport_arbiter.sv
// Directed and randomized checks of the fetch/data bus arbiter against a
// request-level reference model (winner choice, streak limit, response kind).
module tb_rv32i_memport_arbiter;
  localparam int MAX_D = 4;
  localparam int TMO   = 255;

  logic        clk, rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_sel;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        m_stb, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic        m_ack, m_err, busy;

  rv32i_memport_arbiter #(.TIMEOUT(TMO), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: pending requests, their fields, streak, last read data
  bit          ip, dp;
  logic [31:0] ia, da, dw;
  logic        dwe;
  logic [3:0]  dsel;
  int          streak;
  logic [31:0] exp_ir, exp_dr;
  bit          ir_known, dr_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    i_req = ip; i_addr = ia;
    d_req = dp; d_addr = da; d_we = dwe; d_wdata = dw; d_sel = dsel;
  endtask

  // Entered and left at a negedge with the arbiter idle.
  // kind: 0 = ack, 1 = err, 2 = ack and err together
  task automatic transact(input int delay, input int kind, input logic [31:0] rd,
                          input bit hold, output bit won_d);
    bit          wd;
    logic [31:0] ea, ew;
    logic        ewe;
    logic [3:0]  es, eresp;
    wd = dp && (!ip || streak < MAX_D);
    if (!wd) streak = 0;
    else if (ip && streak < MAX_D) streak++;
    ea  = wd ? da : ia;
    ewe = wd ? dwe : 1'b0;
    ew  = wd ? dw : 32'h0;
    es  = wd ? dsel : 4'hF;
    drive_reqs();
    check("idle_busy", busy, 0);
    @(negedge clk);
    for (int c = 0; c <= delay; c++) begin
      check("stb",   m_stb, 1);
      check("addr",  m_addr, ea);
      check("we",    m_we, ewe);
      check("wdata", m_wdata, ew);
      check("sel",   m_sel, es);
      check("busy",  busy, 1);
      check("no_resp_yet", {i_ack, i_err, d_ack, d_err}, 0);
      if (c == delay) begin
        m_ack = (kind != 1); m_err = (kind != 0); m_rdata = rd;
      end
      @(negedge clk);
    end
    m_ack = 1'b0; m_err = 1'b0;
    eresp = wd ? {2'b00, kind == 0, kind != 0} : {kind == 0, kind != 0, 2'b00};
    check("stb_drop", m_stb, 0);
    check("resp", {i_ack, i_err, d_ack, d_err}, eresp);
    if (kind == 0) begin
      if (wd) begin exp_dr = rd; dr_known = 1; end
      else    begin exp_ir = rd; ir_known = 1; end
    end else if (kind == 2) begin
      if (wd) dr_known = 0; else ir_known = 0;
    end
    if (ir_known) check("i_rdata", i_rdata, exp_ir);
    if (dr_known) check("d_rdata", d_rdata, exp_dr);
    if (!hold) begin
      if (wd) dp = 0; else ip = 0;
      drive_reqs();
    end
    @(negedge clk);
    check("resp_single", {i_ack, i_err, d_ack, d_err}, 0);
    check("back_idle", busy, 0);
    won_d = wd;
  endtask

  bit won;
  bit ord [10];
  int n, r, kind;

  initial begin
    ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst_n = 1'b0; m_ack = 0; m_err = 0; m_rdata = 0;
    ip = 0; dp = 0; ia = 0; da = 0; dw = 0; dwe = 0; dsel = 0;
    streak = 0; exp_ir = 0; exp_dr = 0; ir_known = 1; dr_known = 1;
    drive_reqs();
    #1;
    check("rst_busy", busy, 0);
    check("rst_stb", m_stb, 0);
    check("rst_resp", {i_ack, i_err, d_ack, d_err}, 0);
    check("rst_bus", {m_we, m_sel}, 0);
    check("rst_addr", m_addr, 0);
    check("rst_irdata", i_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    // single fetch, immediate ack
    ip = 1; ia = 32'h100;
    transact(0, 0, 32'hDEADBEEF, 0, won);
    check("fetch_owner", won, 0);

    // both requests held: streak-limited data priority
    ip = 1; dp = 1; ia = 32'h0000_4000; da = 32'h0000_8000; dwe = 0; dw = 32'h0; dsel = 4'hF;
    for (int k = 0; k < 10; k++) begin
      transact(0, 0, $urandom, 1, won);
      check("grant_order", won, ord[k]);
    end
    ip = 0; dp = 0; drive_reqs();

    // data write, stb held several cycles
    dp = 1; dwe = 1; da = 32'h2000; dw = 32'h12345678; dsel = 4'b0011;
    transact(3, 0, 32'hA5A5_0001, 0, won);
    dwe = 0;

    // bus never answers: timeout
    dp = 1; da = 32'h3000; dsel = 4'hF;
    drive_reqs();
    @(negedge clk);
    n = 0;
    while (m_stb === 1'b1 && n < 300) begin
      check("tmo_no_resp", {i_ack, i_err, d_ack, d_err}, 0);
      n++;
      @(negedge clk);
    end
    check("tmo_len", n, TMO);
    check("tmo_err", {i_ack, i_err, d_ack, d_err}, 4'b0001);
    dp = 0; drive_reqs();
    @(negedge clk);
    check("tmo_single", {i_ack, i_err, d_ack, d_err}, 0);
    m_ack = 1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    m_ack = 0;
    check("late_ack_resp", {i_ack, i_err, d_ack, d_err}, 0);
    check("late_ack_busy", busy, 0);
    check("late_ack_stb", m_stb, 0);
    check("late_ack_rdata", d_rdata, exp_dr);
    @(negedge clk);
    check("late_ack_resp2", {i_ack, i_err, d_ack, d_err}, 0);

    // randomized mix of requests, delays and response kinds
    for (int t = 0; t < 60; t++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = $urandom_range(0, 1) == 1;
        dsel = 4'($urandom_range(0, 15));
      end
      if (!ip && !dp) begin ip = 1; ia = $urandom; end
      r = $urandom_range(0, 7);
      kind = (r < 6) ? 0 : (r == 6 ? 1 : 2);
      transact($urandom_range(0, 3), kind, $urandom, 0, won);
    end
    ip = 0; dp = 0; drive_reqs();
    @(negedge clk);

    // ack and err together, then reset in mid-transfer
    dp = 1; da = 32'h5000; dwe = 0; dsel = 4'hF;
    transact(0, 2, 32'h7777_7777, 0, won);
    ip = 1; ia = 32'h600;
    drive_reqs();
    @(negedge clk);
    check("pre_rst_stb", m_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_stb", m_stb, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_resp", {i_ack, i_err, d_ack, d_err}, 0);
    ip = 0; drive_reqs();
    @(negedge clk);
    check("rst_hold_resp", {i_ack, i_err, d_ack, d_err}, 0);
    rst_n = 1'b1;
    streak = 0; exp_ir = 0; exp_dr = 0; ir_known = 1; dr_known = 1;
    @(negedge clk);
    check("after_rst_busy", busy, 0);
    check("after_rst_resp", {i_ack, i_err, d_ack, d_err}, 0);
    check("after_rst_stb", m_stb, 0);
    ip = 1; ia = 32'h700;
    transact(1, 0, 32'h0BAD_F00D, 0, won);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
